// File: rtl/packet_window_ram.sv
// Packet store: byte-enabled word writes, unaligned big-endian byte/half/word reads with length-based OOB flag.
// Latency: read accepted at edge N returns rd_data/rd_oob/rd_valid at edge N+2; len updates at the write edge.
// Backpressure: none; one read per cycle, a read coinciding with a write is discarded and flagged by rd_drop.
module packet_window_ram #(
  parameter int BYTE_ADDR_WIDTH = 12,
  parameter int DATA_WIDTH      = 32,
  localparam int W  = DATA_WIDTH / 8,
  localparam int LW = $clog2(W),
  localparam int WA = BYTE_ADDR_WIDTH - LW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WA-1:0]              wr_addr,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic [W-1:0]               wr_be,
  input  logic                       len_clr,
  output logic [BYTE_ADDR_WIDTH:0]   len,
  input  logic                       rd_en,
  input  logic [BYTE_ADDR_WIDTH-1:0] rd_addr,
  input  logic [1:0]                 rd_size,
  output logic                       rd_valid,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       rd_oob,
  output logic                       rd_drop
);

  localparam int LENW  = BYTE_ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << WA;

  // Word storage; lane W-1 holds the lowest byte address of the word
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Port outputs and their output registers (no reset, like BRAM primitives)
  logic [DATA_WIDTH-1:0] ram_a;
  logic [DATA_WIDTH-1:0] ram_b;
  logic [DATA_WIDTH-1:0] ram_a_q;
  logic [DATA_WIDTH-1:0] ram_b_q;

  // Write-side length bookkeeping
  logic [LW-1:0]   wr_low;
  logic            wr_any;
  logic [LENW-1:0] wr_end;

  // Read accept and address decode
  logic            rd_acc;
  logic [WA-1:0]   rd_word;
  logic [WA-1:0]   rd_word_nx;
  logic [LENW-1:0] rd_span;
  logic            acc_oob;

  // Pipeline stage 1 (BRAM read) and stage 2 (BRAM output register)
  logic          p1_vld;
  logic [LW-1:0] p1_off;
  logic [1:0]    p1_size;
  logic          p1_oob;
  logic          p2_vld;
  logic [LW-1:0] p2_off;
  logic [1:0]    p2_size;
  logic          p2_oob;

  // Extraction
  logic [2*DATA_WIDTH-1:0] cat_sh;
  logic [DATA_WIDTH-1:0]   top;
  logic [LW:0]             nbytes;
  logic [LW:0]             drop_bytes;
  logic [DATA_WIDTH-1:0]   ext;

  // A read only goes ahead when port A is not busy writing
  assign rd_acc     = rd_en & ~wr_en;
  assign rd_word    = rd_addr[BYTE_ADDR_WIDTH-1:LW];
  assign rd_word_nx = rd_word + WA'(1);

  // Wide enough that the last byte of memory plus a full word cannot wrap
  assign rd_span = LENW'(rd_addr) + (LENW'(1) << rd_size);
  assign acc_oob = rd_span > len;

  // End byte of a write: one past the highest byte address it touches
  always_comb begin
    wr_low = '0;
    wr_any = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (wr_be[i]) begin
        wr_low = LW'(i);
        wr_any = 1'b1;
      end
    end
    wr_end = '0;
    if (wr_any) begin
      wr_end = LENW'({wr_addr, {LW{1'b0}}}) + LENW'(W) - LENW'(wr_low);
    end
  end

  // Dual-port storage: port A writes or reads word k, port B reads word k+1
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < W; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
        end
      end
    end
    if (rd_acc) begin
      ram_a <= mem[rd_word];
      ram_b <= mem[rd_word_nx];
    end
    ram_a_q <= ram_a;
    ram_b_q <= ram_b;
  end

  // Packet length tracking; a clear combined with a write restarts at that write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len <= '0;
    end else if (len_clr) begin
      len <= wr_en ? wr_end : '0;
    end else if (wr_en && wr_any && (wr_end > len)) begin
      len <= wr_end;
    end
  end

  // Shift the word pair so the first byte lands on top, then right-justify the requested bytes
  always_comb begin
    cat_sh = {ram_a_q, ram_b_q} << {p2_off, 3'b000};
    top    = cat_sh[2*DATA_WIDTH-1 -: DATA_WIDTH];
    if (int'(p2_size) > LW) begin
      nbytes = (LW+1)'(W);
    end else begin
      nbytes = (LW+1)'(1) << p2_size;
    end
    drop_bytes = (LW+1)'(W) - nbytes;
    ext        = top >> {drop_bytes, 3'b000};
  end

  // Read pipeline control, result registers and collision pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_vld   <= 1'b0;
      p1_off   <= '0;
      p1_size  <= '0;
      p1_oob   <= 1'b0;
      p2_vld   <= 1'b0;
      p2_off   <= '0;
      p2_size  <= '0;
      p2_oob   <= 1'b0;
      rd_valid <= 1'b0;
      rd_oob   <= 1'b0;
      rd_data  <= '0;
      rd_drop  <= 1'b0;
    end else begin
      p1_vld   <= rd_acc;
      p1_off   <= rd_addr[LW-1:0];
      p1_size  <= rd_size;
      p1_oob   <= acc_oob;
      p2_vld   <= p1_vld;
      p2_off   <= p1_off;
      p2_size  <= p1_size;
      p2_oob   <= p1_oob;
      rd_valid <= p2_vld;
      rd_oob   <= p2_vld & p2_oob;
      rd_data  <= (p2_vld && !p2_oob) ? ext : '0;
      rd_drop  <= rd_en & wr_en;
    end
  end

endmodule

// File: tb/tb_packet_window_ram.sv
module tb_packet_window_ram;

  typedef struct {
    logic [31:0] d;
    logic        oob;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  exp_t        exp_q[$];
  exp_t        c_exp_q[$];

  // Default instance (4 KiB, 32-bit words)
  logic        wr_en = 1'b0;
  logic [9:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic        len_clr = 1'b0;
  logic [12:0] len;
  logic        rd_en = 1'b0;
  logic [11:0] rd_addr = '0;
  logic [1:0]  rd_size = '0;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_oob;
  logic        rd_drop;

  // Small instance (64 bytes) for the top-of-memory boundary
  logic        c_wr_en = 1'b0;
  logic [3:0]  c_wr_addr = '0;
  logic [31:0] c_wr_data = '0;
  logic [3:0]  c_wr_be = '0;
  logic        c_len_clr = 1'b0;
  logic [6:0]  c_len;
  logic        c_rd_en = 1'b0;
  logic [5:0]  c_rd_addr = '0;
  logic [1:0]  c_rd_size = '0;
  logic        c_rd_valid;
  logic [31:0] c_rd_data;
  logic        c_rd_oob;
  logic        c_rd_drop;

  packet_window_ram dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .len_clr(len_clr), .len(len),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_size(rd_size),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_oob(rd_oob), .rd_drop(rd_drop)
  );

  packet_window_ram #(.BYTE_ADDR_WIDTH(6), .DATA_WIDTH(32)) dut_c (
    .clk(clk), .rst(rst),
    .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data), .wr_be(c_wr_be),
    .len_clr(c_len_clr), .len(c_len),
    .rd_en(c_rd_en), .rd_addr(c_rd_addr), .rd_size(c_rd_size),
    .rd_valid(c_rd_valid), .rd_data(c_rd_data), .rd_oob(c_rd_oob), .rd_drop(c_rd_drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be, input logic clr);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be; len_clr = clr;
    tick();
    wr_en = 1'b0; wr_be = '0; len_clr = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] a, input logic [1:0] sz, input logic [31:0] d, input logic oob);
    exp_t e;
    rd_en = 1'b1; rd_addr = a; rd_size = sz;
    e.d = d; e.oob = oob; e.cyc = cyc + 3;
    exp_q.push_back(e);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic c_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    c_wr_en = 1'b1; c_wr_addr = a; c_wr_data = d; c_wr_be = be;
    tick();
    c_wr_en = 1'b0; c_wr_be = '0;
  endtask

  task automatic c_read(input logic [5:0] a, input logic [1:0] sz, input logic [31:0] d, input logic oob);
    exp_t e;
    c_rd_en = 1'b1; c_rd_addr = a; c_rd_size = sz;
    e.d = d; e.oob = oob; e.cyc = cyc + 3;
    c_exp_q.push_back(e);
    tick();
    c_rd_en = 1'b0;
  endtask

  // Monitor for the default instance
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rd_valid", {32'd0, rd_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rd_data", {32'd0, rd_data}, {32'd0, e.d});
        check("rd_oob", {63'd0, rd_oob}, {63'd0, e.oob});
        check("rd_latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Monitor for the small instance
  always @(negedge clk) begin
    if (c_rd_valid) begin
      if (c_exp_q.size() == 0) begin
        check("c_unexpected_rd_valid", {32'd0, c_rd_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = c_exp_q.pop_front();
        check("c_rd_data", {32'd0, c_rd_data}, {32'd0, e.d});
        check("c_rd_oob", {63'd0, c_rd_oob}, {63'd0, e.oob});
        check("c_rd_latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    logic [31:0] halves [8];
    halves = '{32'h0011, 32'h1122, 32'h2233, 32'h3344, 32'h4455, 32'h5566, 32'h6677, 32'h0};

    tick();
    tick();
    check("reset_len", 64'(len), 64'd0);
    check("reset_rd_valid", {63'd0, rd_valid}, 64'd0);
    check("reset_rd_drop", {63'd0, rd_drop}, 64'd0);
    check("reset_rd_data", {32'd0, rd_data}, 64'd0);
    rst = 1'b0;
    tick();

    // Empty packet: any read is out of bounds
    do_read(12'd0, 2'd2, 32'h0, 1'b1);
    tick();
    tick();

    // Known filler behind the packet, then clear the length
    do_write(10'd2, 32'h9999_9999, 4'hF, 1'b0);
    do_write(10'd3, 32'h9999_9999, 4'hF, 1'b0);
    check("len_after_fill", 64'(len), 64'd16);
    len_clr = 1'b1;
    tick();
    len_clr = 1'b0;
    check("len_after_clr", 64'(len), 64'd0);

    do_write(10'd0, 32'h0011_2233, 4'hF, 1'b0);
    check("len_word0", 64'(len), 64'd4);
    do_write(10'd1, 32'h4455_6677, 4'hF, 1'b0);
    check("len_word1", 64'(len), 64'd8);

    do_read(12'd3, 2'd2, 32'h3344_5566, 1'b0);
    do_read(12'd7, 2'd0, 32'h0000_0077, 1'b0);
    do_read(12'd7, 2'd1, 32'h0, 1'b1);
    tick();

    // Back-to-back halves across the word boundary, last one past len=8
    for (int i = 0; i < 8; i++) begin
      do_read(12'(i), 2'd1, halves[i], (i == 7));
    end
    tick();
    tick();

    // Partial write of one byte at address 10
    do_write(10'd2, 32'hAABB_CCDD, 4'b0010, 1'b0);
    check("len_partial", 64'(len), 64'd11);
    do_read(12'd10, 2'd0, 32'h0000_00CC, 1'b0);
    do_read(12'd9, 2'd0, 32'h0000_0099, 1'b0);
    do_read(12'd11, 2'd0, 32'h0, 1'b1);
    tick();

    // Collision: write wins, read dropped
    wr_en = 1'b1; wr_addr = 10'd3; wr_data = 32'h1234_5678; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 12'd0; rd_size = 2'd2;
    tick();
    wr_en = 1'b0; wr_be = '0; rd_en = 1'b0;
    check("rd_drop_pulse", {63'd0, rd_drop}, 64'd1);
    check("len_collision", 64'(len), 64'd16);
    tick();
    check("rd_drop_clear", {63'd0, rd_drop}, 64'd0);
    do_read(12'd12, 2'd2, 32'h1234_5678, 1'b0);
    do_read(12'd13, 2'd2, 32'h0, 1'b1);
    tick();
    tick();

    // Clear combined with a two-byte write
    do_write(10'd0, 32'hDEAD_0000, 4'hC, 1'b1);
    check("len_clr_write", 64'(len), 64'd2);
    do_write(10'd3, 32'hFFFF_FFFF, 4'h0, 1'b0);
    check("len_be_zero", 64'(len), 64'd2);
    do_read(12'd0, 2'd1, 32'h0000_DEAD, 1'b0);
    do_read(12'd1, 2'd1, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) tick();

    // Reset while a read is in flight
    rd_en = 1'b1; rd_addr = 12'd0; rd_size = 2'd1;
    tick();
    rd_en = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("len_async_reset", 64'(len), 64'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rd_valid_after_reset", {63'd0, rd_valid}, 64'd0);
      tick();
    end
    do_read(12'd0, 2'd0, 32'h0, 1'b1);

    // Top-of-memory boundary on the 64-byte instance
    c_write(4'd15, 32'hCAFE_F00D, 4'hF);
    check("c_len_last", 64'(c_len), 64'd64);
    c_write(4'd0, 32'h0102_0304, 4'hF);
    check("c_len_hold", 64'(c_len), 64'd64);
    c_read(6'd62, 2'd2, 32'h0, 1'b1);
    c_read(6'd62, 2'd1, 32'h0000_F00D, 1'b0);
    c_read(6'd60, 2'd2, 32'hCAFE_F00D, 1'b0);
    c_read(6'd63, 2'd0, 32'h0000_000D, 1'b0);

    for (int i = 0; i < 50 && (exp_q.size() != 0 || c_exp_q.size() != 0); i++) tick();
    tick();
    check("pending_reads", 64'(exp_q.size()), 64'd0);
    check("c_pending_reads", 64'(c_exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
